// File: rtl/rev_pkg.sv
// Shared definitions for the wheel revolution front-end and the downstream counter.
package rev_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      CONF_HIGH = 2'd1,
      HIGH      = 2'd2,
      CONF_LOW  = 2'd3
   } db_state_t;

   localparam logic       STALLED_RST = 1'b1;
   localparam logic [6:0] ASCII_ZERO  = 7'h30;

   function automatic int unsigned cycles_per_ms(input int unsigned freq);
      return freq / 1000;
   endfunction

endpackage

// File: rtl/rev_debounce.sv
// Two-flop synchroniser plus four-state debounce FSM; emits a registered one-cycle
// pulse on every debounced rising edge of the reed switch.
module rev_debounce
   import rev_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor_raw,
   output logic rev_level,
   output logic rev_rise
);

   localparam int unsigned    CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync_p0;
   logic             s_sync;
   db_state_t        state;
   db_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0  <= 1'b0;
         s_sync   <= 1'b0;
         state    <= LOW;
         cnt      <= '0;
         rev_rise <= 1'b0;
      end else begin
         sync_p0  <= sensor_raw;
         s_sync   <= sync_p0;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rev_rise <= (state == CONF_HIGH) && (state_nxt == HIGH);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         LOW: begin
            if (s_sync) begin
               state_nxt = CONF_HIGH;
               cnt_nxt   = '0;
            end
         end
         CONF_HIGH: begin
            if (!s_sync)                state_nxt = LOW;
            else if (cnt == CNT_LAST)   state_nxt = HIGH;
            else                        cnt_nxt   = cnt + 1'b1;
         end
         HIGH: begin
            if (!s_sync) begin
               state_nxt = CONF_LOW;
               cnt_nxt   = '0;
            end
         end
         CONF_LOW: begin
            if (s_sync)                 state_nxt = HIGH;
            else if (cnt == CNT_LAST)   state_nxt = LOW;
            else                        cnt_nxt   = cnt + 1'b1;
         end
         default: state_nxt = LOW;
      endcase
   end

   assign rev_level = (state == HIGH) || (state == CONF_LOW);

endmodule

// File: rtl/rev_conditioner.sv
// Wheel sensor conditioner: debounced revolution pulse, ms period measurement and stall flag.
// Optional REV_MIN_PERIOD_EN rejects implausibly fast revolutions and adds the rev_reject port.
module rev_conditioner
   import rev_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
   parameter int unsigned DEBOUNCE_MS   = 5,
   parameter int unsigned TIMEOUT_MS    = 3000,
   parameter int unsigned PERIOD_W      = 16,
   parameter int unsigned MIN_PERIOD_MS = 60
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sensor_raw,
   output logic                rev_level,
   output logic                rev_pulse,
   output logic [PERIOD_W-1:0] period_ms,
   output logic                period_valid,
   output logic                stalled
`ifdef REV_MIN_PERIOD_EN
   ,
   output logic                rev_reject
`endif
);

   localparam int unsigned CYCLES_PER_MS = cycles_per_ms(CLK_FREQ_HZ);
   localparam int unsigned DB_CYCLES     = DEBOUNCE_MS * CYCLES_PER_MS;
   localparam int unsigned PRE_W         = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
   localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(CYCLES_PER_MS - 1);
   localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT_MS);
   localparam logic [PERIOD_W-1:0] MIN_V     = PERIOD_W'(MIN_PERIOD_MS);
`ifdef REV_MIN_PERIOD_EN
   localparam logic MIN_EN = 1'b1;
`else
   localparam logic MIN_EN = 1'b0;
`endif

   function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
      return (v == {PERIOD_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic                rev_rise;
   logic                reject;
   logic                accept;
   logic                tick;
   logic [PRE_W-1:0]    pre;
   logic [PERIOD_W-1:0] ms_since;
   logic [PERIOD_W-1:0] ms_inc;
   logic                seen_one;

   rev_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .sensor_raw (sensor_raw),
      .rev_level  (rev_level),
      .rev_rise   (rev_rise)
   );

   // A rejected edge leaves the period state untouched, so ms_since keeps running.
   assign reject    = MIN_EN && rev_rise && seen_one && (ms_since < MIN_V);
   assign accept    = rev_rise && !reject;
   assign rev_pulse = accept;
   assign tick      = (pre == PRE_LAST);
   assign ms_inc    = sat_inc(ms_since);
`ifdef REV_MIN_PERIOD_EN
   assign rev_reject = reject;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre          <= '0;
         ms_since     <= '0;
         seen_one     <= 1'b0;
         period_ms    <= '0;
         period_valid <= 1'b0;
         stalled      <= STALLED_RST;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         // Revolution beats a coincident tick and a coincident timeout.
         if (accept) begin
            if (seen_one) begin
               period_ms    <= ms_since;
               period_valid <= 1'b1;
            end
            ms_since <= '0;
            seen_one <= 1'b1;
            stalled  <= 1'b0;
         end else if (tick) begin
            ms_since <= ms_inc;
            if (ms_inc == TIMEOUT_V) begin
               stalled      <= 1'b1;
               period_valid <= 1'b0;
               seen_one     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rev_conditioner.sv
// Scoreboard bench for rev_conditioner at 10 cycles/ms, 10-cycle debounce, 50 ms timeout.
module tb_rev_conditioner;

   logic        clk = 1'b0;
   logic        reset;
   logic        sensor_raw;
   logic        rev_level;
   logic        rev_pulse;
   logic [15:0] period_ms;
   logic        period_valid;
   logic        stalled;
`ifdef REV_MIN_PERIOD_EN
   logic        rev_reject;
`endif

   rev_conditioner #(
      .CLK_FREQ_HZ   (10_000),
      .DEBOUNCE_MS   (1),
      .TIMEOUT_MS    (50),
      .PERIOD_W      (16),
      .MIN_PERIOD_MS (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sensor_raw   (sensor_raw),
      .rev_level    (rev_level),
      .rev_pulse    (rev_pulse),
      .period_ms    (period_ms),
      .period_valid (period_valid),
      .stalled      (stalled)
`ifdef REV_MIN_PERIOD_EN
      ,
      .rev_reject   (rev_reject)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit chk_per;
      bit valid;
   } exp_t;

   exp_t q[$];
   int   rej_q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   errors = 0;
   bit   pending = 1'b0;
   exp_t pend_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int lo, input int hi);
      vectors++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
      end
   endtask

   // Monitor: pops the expected revolution when the DUT pulses, checks period state next cycle.
   always @(negedge clk) begin
      if (reset) begin
         pending <= 1'b0;
      end else begin
         if (pending) begin
            chk("post_valid", int'(period_valid), int'(pend_e.valid), int'(pend_e.valid));
            chk("post_stalled", int'(stalled), 0, 0);
            if (pend_e.chk_per) chk("post_period", int'(period_ms), 19, 21);
            pending <= 1'b0;
         end
         if (rev_pulse) begin
            if (q.size() == 0) begin
               chk("unexpected_pulse", 1, 0, 0);
            end else begin
               pend_e = q.pop_front();
               chk("pulse_cycle", cyc, pend_e.cyc, pend_e.cyc);
               pending <= 1'b1;
            end
         end
`ifdef REV_MIN_PERIOD_EN
         if (rev_reject) begin
            if (rej_q.size() == 0) chk("unexpected_reject", 1, 0, 0);
            else chk("reject_cycle", cyc, rej_q[0], rej_q[0]);
            if (rej_q.size() != 0) void'(rej_q.pop_front());
         end
`endif
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rev(input int hi, input int total, input bit pulse, input bit chk_per,
                      input bit valid);
      exp_t e;
      sensor_raw = 1'b1;
      if (pulse) begin
         e.cyc = cyc + 13;
         e.chk_per = chk_per;
         e.valid = valid;
         q.push_back(e);
      end
      step(hi);
      sensor_raw = 1'b0;
      step(total - hi);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_level"}, int'(rev_level), 0, 0);
      chk({tag, "_pulse"}, int'(rev_pulse), 0, 0);
      chk({tag, "_period"}, int'(period_ms), 0, 0);
      chk({tag, "_valid"}, int'(period_valid), 0, 0);
      chk({tag, "_stalled"}, int'(stalled), 1, 1);
   endtask

   initial begin
      reset = 1'b1;
      sensor_raw = 1'b0;
      step(3);
      chk_reset_values("rst");
      reset = 1'b0;

      step(100);
      chk("idle_stalled", int'(stalled), 1, 1);
      chk("idle_valid", int'(period_valid), 0, 0);
      chk("idle_period", int'(period_ms), 0, 0);

      // Bounce: 3 cycles high / 3 low, ending low, then a clean hold.
      for (int i = 0; i < 40; i++) begin
         sensor_raw = ((i / 3) % 2 == 0);
         step(1);
      end
      rev(15, 15, 1'b1, 1'b0, 1'b0);
      chk("hold_level", int'(rev_level), 1, 1);
      chk("hold_stalled", int'(stalled), 0, 0);
      chk("hold_valid", int'(period_valid), 0, 0);
      step(5);
      sensor_raw = 1'b0;
      step(180);

      rev(20, 200, 1'b1, 1'b1, 1'b1);
      rev(20, 200, 1'b1, 1'b1, 1'b1);

      // Stall: the last accept is 186 cycles back; timeout lands ~500 cycles after it.
      step(280);
      chk("prestall_stalled", int'(stalled), 0, 0);
      step(70);
      chk("stall_stalled", int'(stalled), 1, 1);
      chk("stall_valid", int'(period_valid), 0, 0);
      chk("stall_period", int'(period_ms), 19, 21);
      rev(20, 200, 1'b1, 1'b1, 1'b0);
      chk("unstall_valid", int'(period_valid), 0, 0);

      // Reset 5 cycles into CONF_HIGH.
      sensor_raw = 1'b1;
      step(8);
      reset = 1'b1;
      sensor_raw = 1'b0;
      #1;
      chk_reset_values("midrst");
      step(3);
      reset = 1'b0;
      step(50);
      rev(20, 200, 1'b1, 1'b0, 1'b0);

`ifdef REV_MIN_PERIOD_EN
      rev(15, 30, 1'b1, 1'b1, 1'b1);
      rej_q.push_back(cyc + 13);
      rev(15, 170, 1'b0, 1'b0, 1'b0);
      chk("rej_period", int'(period_ms), 19, 21);
      chk("rej_valid", int'(period_valid), 1, 1);
      rev(20, 200, 1'b1, 1'b1, 1'b1);
      chk("rej_drain", rej_q.size(), 0, 0);
`endif

      step(20);
      chk("sb_drain", q.size(), 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/rev_conditioner.md
Name: rev_conditioner

Overview:
- Upstream front-end for the odometer/speedometer counter.
- Takes the raw, asynchronous wheel reed-switch signal and synchronises and debounces it into a single-cycle `rev_pulse` in the `clk` domain.
- Measures the millisecond period between accepted revolutions and flags a stalled wheel.
- The downstream counter consumes `rev_pulse` and `period_ms` instead of clocking on the raw sensor edge.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz.
- DEBOUNCE_MS, 5, time the synchronised input must be stable before a level change is accepted.
- TIMEOUT_MS, 3000, ms without an accepted revolution before `stalled` asserts; must be < 2^PERIOD_W.
- PERIOD_W, 16, width of `period_ms`.
- MIN_PERIOD_MS, 60, minimum plausible revolution period; used only with REV_MIN_PERIOD_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sensor_raw  in  1  raw reed switch, active high, asynchronous to `clk`, bouncy.
- rev_level  out  1  debounced sensor level.
- rev_pulse  out  1  one-cycle pulse per accepted revolution (debounced rising edge).
- period_ms  out  PERIOD_W  ms between the last two accepted revolutions, saturating.
- period_valid  out  1  `period_ms` holds a measurement from two consecutive non-stalled revolutions.
- stalled  out  1  no accepted revolution within TIMEOUT_MS.

Behaviour:
- Reset is asynchronous and active-high and is applied to every flop. Reset values:
  - `rev_level`=0, `rev_pulse`=0, `period_ms`=0, `period_valid`=0, `stalled`=1.
  - Sync flops, prescaler, debounce counter, `ms_since` and `seen_one` all reset to 0.
  - Debounce FSM resets to LOW.
- Synchroniser: 2-flop on `sensor_raw`, giving `s_sync`.
- ms tick: free-running prescaler counts 0..CYCLES_PER_MS-1, where CYCLES_PER_MS = CLK_FREQ_HZ/1000. `tick` is high for one cycle at terminal count, then the prescaler wraps to 0.
- Debounce FSM, with DB_CYCLES = DEBOUNCE_MS*CYCLES_PER_MS:
  - LOW: `s_sync`=1 -> CONF_HIGH, clear counter.
  - CONF_HIGH: `s_sync`=0 -> LOW. Counter reaches DB_CYCLES-1 with `s_sync`=1 -> HIGH.
  - HIGH: `s_sync`=0 -> CONF_LOW, clear counter.
  - CONF_LOW: `s_sync`=1 -> HIGH. Counter reaches DB_CYCLES-1 with `s_sync`=0 -> LOW.
  - `rev_level`=1 in HIGH and CONF_LOW.
  - `rev_pulse` is a registered output, high for exactly one cycle on the CONF_HIGH->HIGH transition.
- Latency: `sensor_raw` stable high -> `rev_pulse` = 2 (sync) + DB_CYCLES + 1 cycles.
- Period measurement:
  - `ms_since` increments on `tick` and saturates at 2^PERIOD_W-1.
  - On an accepted revolution:
    - if `seen_one`=1: `period_ms` <= `ms_since`, `period_valid` <= 1.
    - always: `ms_since` <= 0, `seen_one` <= 1, `stalled` <= 0.
  - On the first revolution after reset or stall, `period_ms` and `period_valid` are unchanged (`period_valid` stays 0).
- Simultaneous `tick` and accepted revolution: the revolution wins, `ms_since` <= 0 and the tick is dropped.
- Stall:
  - When `ms_since` reaches TIMEOUT_MS on a tick: `stalled` <= 1, `period_valid` <= 0, `seen_one` <= 0.
  - `period_ms` holds its last value.
  - A revolution in the same cycle takes priority and no stall occurs.
- Reset mid-debounce or mid-period: every flop returns to reset values immediately. No `rev_pulse` is emitted as a result of reset.

Optional Feature:
- Macro: REV_MIN_PERIOD_EN.
- Defined:
  - A debounced rising edge with `seen_one`=1 and `ms_since` < MIN_PERIOD_MS is rejected: no `rev_pulse`, no `period_ms`/`period_valid`/`ms_since` update.
  - The FSM still enters HIGH.
  - Output `rev_reject` (1 bit) pulses for one cycle on each rejection.
- Undefined: every debounced rising edge is accepted, and the `rev_reject` port is absent.

Decomposition:
- Package `rev_pkg`:
  - `cycles_per_ms(freq)` constant function.
  - Debounce state enum {LOW, CONF_HIGH, HIGH, CONF_LOW}.
  - Reset constants for `stalled` (1) and ASCII zero (7'h30) shared with the counter.
- One sub-module: `rev_debounce`, containing the synchroniser, debounce FSM and `rev_pulse` generation.
- The top level holds the prescaler, `ms_since`, and the period/stall logic.

Test Plan (sim params CLK_FREQ_HZ=10_000 → 10 cycles/ms, DEBOUNCE_MS=1 → DB_CYCLES=10, TIMEOUT_MS=50, PERIOD_W=16, MIN_PERIOD_MS=5):
- Reset release, `sensor_raw`=0 for 100 cycles -> `stalled`=1, `period_valid`=0, `rev_pulse` never high, `period_ms`=0.
- `sensor_raw` toggling every 3 cycles for 40 cycles, then held high -> exactly one `rev_pulse`, 13 cycles after the hold begins; `rev_level`=1; `stalled`=0; `period_valid`=0.
- Clean revolutions 20 ms apart (pulse high 2 ms) -> second `rev_pulse` gives `period_ms`=20±1, `period_valid`=1; third gives `period_ms`=20±1.
- No revolution for 50 ms after a valid period -> `stalled`=1, `period_valid`=0, `period_ms` holds 20±1. The next revolution gives `stalled`=0, `period_valid` still 0.
- Assert reset while in CONF_HIGH (5 cycles in) -> all outputs at reset values next cycle. No `rev_pulse` after release unless a full 10-cycle stable high follows.
- With REV_MIN_PERIOD_EN: revolutions at 20 ms then 3 ms -> second edge gives `rev_reject`=1 for one cycle, no `rev_pulse`, `period_ms` unchanged. The next edge at 20 ms after the last accepted revolution is accepted.
